// File: rtl/id_stage_pkg.sv
// Shared widths, opcode/func codes, alu_op bit positions and bus layouts for the ID stage.
// Pure definitions: no latency and no backpressure of its own.
package id_stage_pkg;

    localparam int IF_BUS_W    = 33;
    localparam int WB_BUS_W    = 38;
    localparam int ID_EX_BUS_W = 159;
    localparam int BR_BUS_W    = 33;

    localparam int STALL_ID = 1;
    localparam int STALL_EX = 2;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // alu_op is one-hot, add in the MSB down to lui in the LSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int SRC1_SA = 2;
    localparam int SRC1_PC = 1;
    localparam int SRC1_RS = 0;

    localparam int SRC2_ZEXT = 3;
    localparam int SRC2_8    = 2;
    localparam int SRC2_SEXT = 1;
    localparam int SRC2_RT   = 0;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] data1;
        logic [31:0] data2;
    } id_to_ex_t;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_t;

    function automatic logic rf_hit(input rf_wr_t w, input logic [4:0] addr);
        return w.we && (w.waddr == addr) && (addr != 5'd0);
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundles the ID stage pipeline buses; slave is the ID stage, master the surrounding pipeline.
// Pure wiring: no latency; backpressure travels as stall/stallreq.
interface id_stage_if #(
    parameter int NUM_FWD = 2,
    parameter int STALL_W = 6
);
    import id_stage_pkg::*;

    logic [STALL_W-1:0]          stall;
    logic                        flush;
    if_to_id_t                   if_to_id_bus;
    logic [31:0]                 inst_sram_rdata;
    rf_wr_t                      wb_to_rf_bus;
    logic [NUM_FWD*WB_BUS_W-1:0] fwd_bus;
    logic                        ex_is_load;
    logic [4:0]                  ex_load_waddr;
    logic                        stallreq;
    id_to_ex_t                   id_to_ex_bus;
    br_t                         br_bus;

    modport master (
        output stall, flush, if_to_id_bus, inst_sram_rdata, wb_to_rf_bus,
               fwd_bus, ex_is_load, ex_load_waddr,
        input  stallreq, id_to_ex_bus, br_bus
    );

    modport slave (
        input  stall, flush, if_to_id_bus, inst_sram_rdata, wb_to_rf_bus,
               fwd_bus, ex_is_load, ex_load_waddr,
        output stallreq, id_to_ex_bus, br_bus
    );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file, one synchronous write port and two combinational read ports; $0 reads 0.
// Latency: write visible the cycle after the edge; no backpressure.
module id_stage_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, instruction hold, operand forwarding, decode, branch resolve.
// Latency: one register from IF, decode combinational; stall holds, flush/bubble zeros, stallreq flags load-use.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int STALL_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_if.slave    bus
);

    if_to_id_t          id_reg;
    logic [31:0]        hold_inst;
    logic               hold_valid;
    logic [STALL_W-1:0] stall_v;
    logic               unused_stall;
    logic               stall_id;
    logic               stall_ex;

    assign stall_v      = bus.stall;
    assign unused_stall = ^stall_v;
    assign stall_id     = stall_v[STALL_ID];
    assign stall_ex     = stall_v[STALL_EX];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_reg     <= '0;
            hold_inst  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (bus.flush || (stall_id && !stall_ex)) begin
                id_reg <= '0;
            end else if (!stall_id) begin
                id_reg <= bus.if_to_id_bus;
            end
            // The SRAM only presents the word for one cycle, so keep it while ID is frozen
            if (bus.flush || !stall_id || !stall_ex) begin
                hold_valid <= 1'b0;
            end else if (!hold_valid && id_reg.ce) begin
                hold_inst  <= bus.inst_sram_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

    logic [31:0] inst;
    assign inst = !id_reg.ce ? 32'd0 : (hold_valid ? hold_inst : bus.inst_sram_rdata);

    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] index;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign func  = inst[5:0];
    assign imm   = inst[15:0];
    assign index = inst[25:0];

    rf_wr_t      wb;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;

    assign wb = bus.wb_to_rf_bus;

    id_stage_regfile u_regfile (
        .clk    (clk),
        .we     (wb.we),
        .waddr  (wb.waddr),
        .wdata  (wb.wdata),
        .raddr1 (rs),
        .rdata1 (rf_rdata1),
        .raddr2 (rt),
        .rdata2 (rf_rdata2)
    );

    // Entry i of fwd_bus sits at bits [i*38 +: 38]; entry 0 is the youngest producer
    rf_wr_t             fwd_src [NUM_FWD];
    logic [NUM_FWD-1:0] hit1;
    logic [NUM_FWD-1:0] hit2;

    for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
        assign fwd_src[i] = bus.fwd_bus[i*WB_BUS_W +: WB_BUS_W];
        assign hit1[i]    = rf_hit(fwd_src[i], rs);
        assign hit2[i]    = rf_hit(fwd_src[i], rt);
    end

    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [31:0] data1;
    logic [31:0] data2;

    always_comb begin
        fwd1 = rf_hit(wb, rs) ? wb.wdata : rf_rdata1;
        fwd2 = rf_hit(wb, rt) ? wb.wdata : rf_rdata2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hit1[i]) fwd1 = fwd_src[i].wdata;
            if (hit2[i]) fwd2 = fwd_src[i].wdata;
        end
    end

    assign data1 = (rs == 5'd0) ? 32'd0 : fwd1;
    assign data2 = (rt == 5'd0) ? 32'd0 : fwd2;

    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic        reads_rs;
    logic        reads_rt;
    logic        is_beq;
    logic        is_bne;
    logic        is_jimm;
    logic        is_jreg;
    logic        r_rr;
    logic        r_sh;
    logic        i_alu;

    always_comb begin
        alu_op     = '0;
        sel_src1   = '0;
        sel_src2   = '0;
        ram_en     = 1'b0;
        ram_wen    = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        sel_rf_res = 1'b0;
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_jimm    = 1'b0;
        is_jreg    = 1'b0;
        r_rr       = 1'b0;
        r_sh       = 1'b0;
        i_alu      = 1'b0;
        if (id_reg.ce) begin
            case (op)
                OP_SPECIAL: begin
                    case (func)
                        FN_ADDU: begin alu_op[ALU_ADD]  = 1'b1; r_rr = 1'b1; end
                        FN_SUBU: begin alu_op[ALU_SUB]  = 1'b1; r_rr = 1'b1; end
                        FN_SLT:  begin alu_op[ALU_SLT]  = 1'b1; r_rr = 1'b1; end
                        FN_SLTU: begin alu_op[ALU_SLTU] = 1'b1; r_rr = 1'b1; end
                        FN_AND:  begin alu_op[ALU_AND]  = 1'b1; r_rr = 1'b1; end
                        FN_OR:   begin alu_op[ALU_OR]   = 1'b1; r_rr = 1'b1; end
                        FN_XOR:  begin alu_op[ALU_XOR]  = 1'b1; r_rr = 1'b1; end
                        FN_NOR:  begin alu_op[ALU_NOR]  = 1'b1; r_rr = 1'b1; end
                        FN_SLL:  begin alu_op[ALU_SLL]  = 1'b1; r_sh = 1'b1; end
                        FN_SRL:  begin alu_op[ALU_SRL]  = 1'b1; r_sh = 1'b1; end
                        FN_SRA:  begin alu_op[ALU_SRA]  = 1'b1; r_sh = 1'b1; end
                        FN_JR:   begin is_jreg = 1'b1; reads_rs = 1'b1; end
                        FN_JALR: begin
                            is_jreg           = 1'b1;
                            reads_rs          = 1'b1;
                            alu_op[ALU_ADD]   = 1'b1;
                            sel_src1[SRC1_PC] = 1'b1;
                            sel_src2[SRC2_8]  = 1'b1;
                            rf_we             = 1'b1;
                            rf_waddr          = rd;
                        end
                        default: ;
                    endcase
                end
                OP_ADDIU: begin alu_op[ALU_ADD]  = 1'b1; sel_src2[SRC2_SEXT] = 1'b1; i_alu = 1'b1; end
                OP_SLTI:  begin alu_op[ALU_SLT]  = 1'b1; sel_src2[SRC2_SEXT] = 1'b1; i_alu = 1'b1; end
                OP_SLTIU: begin alu_op[ALU_SLTU] = 1'b1; sel_src2[SRC2_SEXT] = 1'b1; i_alu = 1'b1; end
                OP_ANDI:  begin alu_op[ALU_AND]  = 1'b1; sel_src2[SRC2_ZEXT] = 1'b1; i_alu = 1'b1; end
                OP_ORI:   begin alu_op[ALU_OR]   = 1'b1; sel_src2[SRC2_ZEXT] = 1'b1; i_alu = 1'b1; end
                OP_XORI:  begin alu_op[ALU_XOR]  = 1'b1; sel_src2[SRC2_ZEXT] = 1'b1; i_alu = 1'b1; end
                OP_LUI: begin
                    alu_op[ALU_LUI]     = 1'b1;
                    sel_src2[SRC2_ZEXT] = 1'b1;
                    rf_we               = 1'b1;
                    rf_waddr            = rt;
                end
                OP_J: is_jimm = 1'b1;
                OP_JAL: begin
                    is_jimm           = 1'b1;
                    alu_op[ALU_ADD]   = 1'b1;
                    sel_src1[SRC1_PC] = 1'b1;
                    sel_src2[SRC2_8]  = 1'b1;
                    rf_we             = 1'b1;
                    rf_waddr          = 5'd31;
                end
                OP_BEQ: begin is_beq = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
                OP_BNE: begin is_bne = 1'b1; reads_rs = 1'b1; reads_rt = 1'b1; end
                OP_LW: begin
                    alu_op[ALU_ADD]     = 1'b1;
                    sel_src2[SRC2_SEXT] = 1'b1;
                    i_alu               = 1'b1;
                    ram_en              = 1'b1;
                    sel_rf_res          = 1'b1;
                end
                OP_SW: begin
                    alu_op[ALU_ADD]     = 1'b1;
                    sel_src1[SRC1_RS]   = 1'b1;
                    sel_src2[SRC2_SEXT] = 1'b1;
                    reads_rs            = 1'b1;
                    reads_rt            = 1'b1;
                    ram_en              = 1'b1;
                    ram_wen             = 4'b1111;
                end
                default: ;
            endcase
            if (r_rr) begin
                sel_src1[SRC1_RS] = 1'b1;
                sel_src2[SRC2_RT] = 1'b1;
                reads_rs          = 1'b1;
                reads_rt          = 1'b1;
                rf_we             = 1'b1;
                rf_waddr          = rd;
            end
            if (r_sh) begin
                sel_src1[SRC1_SA] = 1'b1;
                sel_src2[SRC2_RT] = 1'b1;
                reads_rt          = 1'b1;
                rf_we             = 1'b1;
                rf_waddr          = rd;
            end
            if (i_alu) begin
                sel_src1[SRC1_RS] = 1'b1;
                reads_rs          = 1'b1;
                rf_we             = 1'b1;
                rf_waddr          = rt;
            end
        end
    end

    logic stallreq;
    assign stallreq = id_reg.ce && bus.ex_is_load && (bus.ex_load_waddr != 5'd0) &&
                      ((reads_rs && (bus.ex_load_waddr == rs)) ||
                       (reads_rt && (bus.ex_load_waddr == rt)));

    logic        br_take;
    logic [31:0] br_addr;

    always_comb begin
        br_take = 1'b0;
        br_addr = '0;
        if (is_beq || is_bne) begin
            br_take = is_beq ? (data1 == data2) : (data1 != data2);
            br_addr = id_reg.pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
        end else if (is_jimm) begin
            br_take = 1'b1;
            br_addr = {id_reg.pc[31:28], index, 2'b00};
        end else if (is_jreg) begin
            br_take = 1'b1;
            br_addr = data1;
        end
    end

    // A load-use hazard turns this slot into a side-effect-free bubble until the load data forwards
    id_to_ex_t out;
    always_comb begin
        out            = '0;
        out.pc         = id_reg.pc;
        out.inst       = inst;
        out.alu_op     = alu_op;
        out.sel_src1   = sel_src1;
        out.sel_src2   = sel_src2;
        out.ram_en     = ram_en && !stallreq;
        out.ram_wen    = ram_wen;
        out.rf_we      = rf_we && !stallreq;
        out.rf_waddr   = rf_waddr;
        out.sel_rf_res = sel_rf_res;
        out.data1      = data1;
        out.data2      = data2;
    end

    assign bus.id_to_ex_bus   = out;
    assign bus.br_bus.br_e    = br_take && !stallreq;
    assign bus.br_bus.br_addr = br_addr;
    assign bus.stallreq       = stallreq;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, forwarding, load-use, hold, branch, memory and flush cases.
module tb_id_stage;
    import id_stage_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    id_stage_if #(.NUM_FWD(2), .STALL_W(6)) ifc ();

    id_stage #(.NUM_FWD(2), .STALL_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    id_to_ex_t o;
    br_t       b;
    assign o = ifc.id_to_ex_bus;
    assign b = ifc.br_bus;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [37:0] wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        @(negedge clk);
        ifc.if_to_id_bus = {1'b1, pc};
        ifc.stall        = 6'b0;
        ifc.flush        = 1'b0;
        @(posedge clk);
        #1 ifc.inst_sram_rdata = inst;
        #1;
    endtask

    task automatic test_reset;
        rst                 = 1'b0;
        ifc.stall           = 6'b0;
        ifc.flush           = 1'b0;
        ifc.if_to_id_bus    = {1'b1, 32'hBFC00000};
        ifc.inst_sram_rdata = 32'hFFFFFFFF;
        ifc.wb_to_rf_bus    = '0;
        ifc.fwd_bus         = '0;
        ifc.ex_is_load      = 1'b0;
        ifc.ex_load_waddr   = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ifc.id_to_ex_bus !== 159'd0) $display("FAIL reset_bus got=%h exp=0", ifc.id_to_ex_bus); else passed++;
        checks++; if (ifc.br_bus !== 33'd0) $display("FAIL reset_br got=%h exp=0", ifc.br_bus); else passed++;
        checks++; if (ifc.stallreq !== 1'b0) $display("FAIL reset_stallreq got=%b exp=0", ifc.stallreq); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ori;
        fetch(32'hBFC00000, i_ins(6'h0d, 5'd0, 5'd1, 16'h1234));
        checks++; if (o.data1 !== 32'h0) $display("FAIL ori_data1 got=%h exp=0", o.data1); else passed++;
        checks++; if (o.rf_waddr !== 5'd1) $display("FAIL ori_waddr got=%0d exp=1", o.rf_waddr); else passed++;
        checks++; if (o.sel_src2 !== 4'b1000) $display("FAIL ori_src2 got=%b exp=1000", o.sel_src2); else passed++;
        checks++; if (o.rf_we !== 1'b1) $display("FAIL ori_rf_we got=%b exp=1", o.rf_we); else passed++;
        checks++; if (o.alu_op !== 12'h020) $display("FAIL ori_alu_op got=%h exp=020", o.alu_op); else passed++;
        checks++; if (o.sel_src1 !== 3'b001) $display("FAIL ori_src1 got=%b exp=001", o.sel_src1); else passed++;
        checks++; if (o.pc !== 32'hBFC00000) $display("FAIL ori_pc got=%h exp=bfc00000", o.pc); else passed++;
        checks++; if (o.inst !== 32'h34011234) $display("FAIL ori_inst got=%h exp=34011234", o.inst); else passed++;
    endtask

    task automatic test_forwarding;
        @(negedge clk);
        ifc.wb_to_rf_bus = {1'b1, 5'd3, 32'h00001111};
        @(posedge clk);
        #1 ifc.wb_to_rf_bus = '0;
        ifc.fwd_bus = {wr(1'b1, 5'd3, 32'hBBBB), wr(1'b1, 5'd3, 32'hAAAA)};
        fetch(32'hBFC00004, r_ins(5'd3, 5'd3, 5'd4, 6'h21));
        checks++; if (o.data1 !== 32'hAAAA) $display("FAIL fwd0_data1 got=%h exp=aaaa", o.data1); else passed++;
        checks++; if (o.data2 !== 32'hAAAA) $display("FAIL fwd0_data2 got=%h exp=aaaa", o.data2); else passed++;
        ifc.fwd_bus = {wr(1'b1, 5'd3, 32'hBBBB), wr(1'b0, 5'd3, 32'hAAAA)};
        #1;
        checks++; if (o.data1 !== 32'hBBBB) $display("FAIL fwd1_data1 got=%h exp=bbbb", o.data1); else passed++;
        ifc.fwd_bus = {wr(1'b1, 5'd0, 32'hBBBB), wr(1'b1, 5'd0, 32'hAAAA)};
        #1;
        checks++; if (o.data1 !== 32'h1111) $display("FAIL fwd_waddr0_regfile got=%h exp=1111", o.data1); else passed++;
        ifc.wb_to_rf_bus = {1'b1, 5'd3, 32'h00002222};
        #1;
        checks++; if (o.data2 !== 32'h2222) $display("FAIL wb_bypass got=%h exp=2222", o.data2); else passed++;
        ifc.wb_to_rf_bus = '0;
        ifc.fwd_bus = {wr(1'b1, 5'd0, 32'hBBBB), wr(1'b1, 5'd0, 32'hCCCC)};
        fetch(32'hBFC00008, r_ins(5'd0, 5'd0, 5'd4, 6'h21));
        checks++; if (o.data1 !== 32'h0) $display("FAIL zero_reg_data1 got=%h exp=0", o.data1); else passed++;
        checks++; if (o.data2 !== 32'h0) $display("FAIL zero_reg_data2 got=%h exp=0", o.data2); else passed++;
        ifc.fwd_bus = '0;
    endtask

    task automatic test_load_use;
        logic [31:0] addu_i;
        addu_i = r_ins(5'd5, 5'd2, 5'd6, 6'h21);
        ifc.ex_is_load    = 1'b1;
        ifc.ex_load_waddr = 5'd5;
        fetch(32'hBFC00010, addu_i);
        checks++; if (ifc.stallreq !== 1'b1) $display("FAIL lu_stallreq got=%b exp=1", ifc.stallreq); else passed++;
        checks++; if (o.rf_we !== 1'b0) $display("FAIL lu_rf_we got=%b exp=0", o.rf_we); else passed++;
        @(negedge clk);
        ifc.stall        = 6'b000111;
        ifc.if_to_id_bus = {1'b1, 32'hBFC00014};
        @(posedge clk);
        #1;
        ifc.ex_is_load      = 1'b0;
        ifc.inst_sram_rdata = 32'hFFFFFFFF;
        ifc.fwd_bus         = {wr(1'b0, 5'd0, 32'h0), wr(1'b1, 5'd5, 32'h5555)};
        #1;
        checks++; if (ifc.stallreq !== 1'b0) $display("FAIL lu_release_stallreq got=%b exp=0", ifc.stallreq); else passed++;
        checks++; if (o.rf_we !== 1'b1) $display("FAIL lu_release_rf_we got=%b exp=1", o.rf_we); else passed++;
        checks++; if (o.rf_waddr !== 5'd6) $display("FAIL lu_release_waddr got=%0d exp=6", o.rf_waddr); else passed++;
        checks++; if (o.data1 !== 32'h5555) $display("FAIL lu_release_data1 got=%h exp=5555", o.data1); else passed++;
        checks++; if (o.inst !== addu_i) $display("FAIL lu_release_inst got=%h exp=%h", o.inst, addu_i); else passed++;
        ifc.fwd_bus       = '0;
        ifc.ex_is_load    = 1'b1;
        ifc.ex_load_waddr = 5'd5;
        fetch(32'hBFC00014, i_ins(6'h0f, 5'd0, 5'd5, 16'h0001));
        checks++; if (ifc.stallreq !== 1'b0) $display("FAIL lu_lui_no_read got=%b exp=0", ifc.stallreq); else passed++;
        fetch(32'hBFC00018, i_ins(6'h04, 5'd0, 5'd5, 16'h0004));
        checks++; if (ifc.stallreq !== 1'b1) $display("FAIL lu_beq_rt_stallreq got=%b exp=1", ifc.stallreq); else passed++;
        checks++; if (b.br_e !== 1'b0) $display("FAIL lu_beq_br_e got=%b exp=0", b.br_e); else passed++;
        ifc.ex_load_waddr = 5'd0;
        fetch(32'hBFC0001C, r_ins(5'd0, 5'd0, 5'd6, 6'h21));
        checks++; if (ifc.stallreq !== 1'b0) $display("FAIL lu_waddr0 got=%b exp=0", ifc.stallreq); else passed++;
        ifc.ex_is_load = 1'b0;
    endtask

    task automatic test_stall_hold;
        logic [31:0] orig;
        logic [31:0] nxt;
        orig = r_ins(5'd1, 5'd2, 5'd8, 6'h26);
        nxt  = i_ins(6'h0d, 5'd0, 5'd9, 16'h00FF);
        fetch(32'hBFC00100, orig);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifc.stall        = 6'b000110;
            ifc.if_to_id_bus = {1'b1, 32'hBFC00200 + 32'(k)};
            @(posedge clk);
            #1 ifc.inst_sram_rdata = 32'hDEAD0000 + 32'(k);
            #1;
            checks++; if (o.inst !== orig) $display("FAIL hold_inst[%0d] got=%h exp=%h", k, o.inst, orig); else passed++;
            checks++; if (o.pc !== 32'hBFC00100) $display("FAIL hold_pc[%0d] got=%h exp=bfc00100", k, o.pc); else passed++;
        end
        fetch(32'hBFC00104, nxt);
        checks++; if (o.inst !== nxt) $display("FAIL hold_resume_inst got=%h exp=%h", o.inst, nxt); else passed++;
        checks++; if (o.pc !== 32'hBFC00104) $display("FAIL hold_resume_pc got=%h exp=bfc00104", o.pc); else passed++;
    endtask

    task automatic test_branch;
        ifc.fwd_bus = {wr(1'b1, 5'd2, 32'h77), wr(1'b1, 5'd1, 32'h77)};
        fetch(32'hBFC00000, i_ins(6'h04, 5'd1, 5'd2, 16'h0004));
        checks++; if (b.br_e !== 1'b1) $display("FAIL beq_taken got=%b exp=1", b.br_e); else passed++;
        checks++; if (b.br_addr !== 32'hBFC00014) $display("FAIL beq_addr got=%h exp=bfc00014", b.br_addr); else passed++;
        checks++; if (o.rf_we !== 1'b0) $display("FAIL beq_rf_we got=%b exp=0", o.rf_we); else passed++;
        fetch(32'hBFC00000, i_ins(6'h05, 5'd1, 5'd2, 16'h0004));
        checks++; if (b.br_e !== 1'b0) $display("FAIL bne_equal got=%b exp=0", b.br_e); else passed++;
        ifc.fwd_bus = {wr(1'b1, 5'd2, 32'h78), wr(1'b1, 5'd1, 32'h77)};
        #1;
        checks++; if (b.br_e !== 1'b1) $display("FAIL bne_differ got=%b exp=1", b.br_e); else passed++;
        fetch(32'hBFC00000, i_ins(6'h04, 5'd1, 5'd2, 16'h0004));
        checks++; if (b.br_e !== 1'b0) $display("FAIL beq_differ got=%b exp=0", b.br_e); else passed++;
        fetch(32'hBFC00000, 32'h08000010);
        checks++; if (b.br_e !== 1'b1) $display("FAIL j_br_e got=%b exp=1", b.br_e); else passed++;
        checks++; if (b.br_addr !== 32'hB0000040) $display("FAIL j_addr got=%h exp=b0000040", b.br_addr); else passed++;
        fetch(32'hBFC00000, 32'h0C000010);
        checks++; if (b.br_addr !== 32'hB0000040) $display("FAIL jal_addr got=%h exp=b0000040", b.br_addr); else passed++;
        checks++; if (o.rf_waddr !== 5'd31) $display("FAIL jal_waddr got=%0d exp=31", o.rf_waddr); else passed++;
        checks++; if ({o.alu_op, o.sel_src1, o.sel_src2} !== {12'h800, 3'b010, 4'b0100})
            $display("FAIL jal_ctrl got=%h/%b/%b exp=800/010/0100", o.alu_op, o.sel_src1, o.sel_src2); else passed++;
        fetch(32'hBFC00000, r_ins(5'd1, 5'd0, 5'd0, 6'h08));
        checks++; if (b.br_addr !== 32'h77 || b.br_e !== 1'b1) $display("FAIL jr got=%b/%h exp=1/00000077", b.br_e, b.br_addr); else passed++;
        ifc.fwd_bus = '0;
    endtask

    task automatic test_mem;
        fetch(32'hBFC00300, i_ins(6'h23, 5'd1, 5'd7, 16'h0008));
        checks++; if ({o.ram_en, o.ram_wen, o.rf_we, o.sel_rf_res} !== 7'b1_0000_1_1)
            $display("FAIL lw_ctrl got=%b exp=1000011", {o.ram_en, o.ram_wen, o.rf_we, o.sel_rf_res}); else passed++;
        checks++; if (o.rf_waddr !== 5'd7) $display("FAIL lw_waddr got=%0d exp=7", o.rf_waddr); else passed++;
        checks++; if (o.sel_src2 !== 4'b0010) $display("FAIL lw_src2 got=%b exp=0010", o.sel_src2); else passed++;
        fetch(32'hBFC00304, i_ins(6'h2b, 5'd1, 5'd7, 16'h0008));
        checks++; if ({o.ram_en, o.ram_wen, o.rf_we} !== 6'b1_1111_0)
            $display("FAIL sw_ctrl got=%b exp=111110", {o.ram_en, o.ram_wen, o.rf_we}); else passed++;
        fetch(32'hBFC00308, i_ins(6'h3f, 5'd1, 5'd7, 16'h0008));
        checks++; if ({o.alu_op, o.rf_we, o.ram_en} !== 14'd0)
            $display("FAIL unknown_op got=%h exp=0", {o.alu_op, o.rf_we, o.ram_en}); else passed++;
    endtask

    task automatic test_flush;
        logic [31:0] fresh;
        fresh = i_ins(6'h0d, 5'd0, 5'd10, 16'h00AA);
        fetch(32'hBFC00400, r_ins(5'd1, 5'd2, 5'd9, 6'h25));
        @(negedge clk);
        ifc.stall = 6'b000110;
        ifc.flush = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (ifc.id_to_ex_bus !== 159'd0) $display("FAIL flush_bubble got=%h exp=0", ifc.id_to_ex_bus); else passed++;
        ifc.flush = 1'b0;
        fetch(32'hBFC00404, r_ins(5'd1, 5'd2, 5'd9, 6'h25));
        @(negedge clk);
        ifc.stall = 6'b000010;
        @(posedge clk);
        #2;
        checks++; if (ifc.id_to_ex_bus !== 159'd0) $display("FAIL stall_bubble got=%h exp=0", ifc.id_to_ex_bus); else passed++;
        fetch(32'hBFC00408, fresh);
        checks++; if (o.inst !== fresh) $display("FAIL flush_resume_inst got=%h exp=%h", o.inst, fresh); else passed++;
    endtask

    task automatic test_reset_mid_stall;
        logic [31:0] fresh;
        fresh = i_ins(6'h0e, 5'd0, 5'd11, 16'h0055);
        fetch(32'hBFC00500, r_ins(5'd1, 5'd2, 5'd12, 6'h21));
        @(negedge clk);
        ifc.stall = 6'b000110;
        @(posedge clk);
        #1 ifc.inst_sram_rdata = 32'hFFFFFFFF;
        #1 rst = 1'b0;
        #1;
        checks++; if (ifc.id_to_ex_bus !== 159'd0) $display("FAIL rst_mid_bus got=%h exp=0", ifc.id_to_ex_bus); else passed++;
        checks++; if (ifc.br_bus !== 33'd0) $display("FAIL rst_mid_br got=%h exp=0", ifc.br_bus); else passed++;
        @(negedge clk);
        rst = 1'b1;
        fetch(32'hBFC00600, fresh);
        checks++; if (o.inst !== fresh) $display("FAIL rst_resume_inst got=%h exp=%h", o.inst, fresh); else passed++;
        checks++; if (o.pc !== 32'hBFC00600) $display("FAIL rst_resume_pc got=%h exp=bfc00600", o.pc); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_ori();
        test_forwarding();
        test_load_use();
        test_stall_hold();
        test_branch();
        test_mem();
        test_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NUM_FWD, default 2, number of forwarding sources (index 0 = youngest, highest priority).
REQ-002 Parameter STALL_W, default 6, width of stall vector.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  STALL_W  per-stage stop vector; bit1 = ID input, bit2 = EX input.
REQ-006 flush  in  1  discard ID contents (branch/exception redirect).
REQ-007 if_to_id_bus  in  33  {ce, pc[31:0]}.
REQ-008 inst_sram_rdata  in  32  instruction fetched for the pc latched last cycle.
REQ-009 wb_to_rf_bus  in  38  {we, waddr[4:0], wdata[31:0]} regfile write port.
REQ-010 fwd_bus  in  NUM_FWD*38  concatenated {we, waddr, wdata} from EX/MEM, MEM/WB, ...
REQ-011 ex_is_load  in  1  instruction now in EX is lw; ex_load_waddr  in  5  its destination.
REQ-012 stallreq  out  1  load-use stall request to the stall controller.
REQ-013 id_to_ex_bus  out  159  {pc, inst, alu_op[11:0], sel_src1[2:0], sel_src2[3:0], ram_en, ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, data1, data2}.
REQ-014 br_bus  out  33  {br_e, br_addr[31:0]}.

Function
REQ-015 Pipeline register: flush or (stall[1]=1 and stall[2]=0) loads zero (bubble); else stall[1]=0 loads if_to_id_bus; else holds.
REQ-016 Instruction hold: first cycle ID is stalled with ce=1, inst_sram_rdata captured into hold register, hold_valid=1; while hold_valid, decoded inst = hold register; hold_valid clears on first unstalled edge or flush.
REQ-017 ce=0 forces inst to 0 (nop): no rf_we, no ram_en, no br_e, stallreq=0.
REQ-018 Operand select per source, priority: fwd_bus[0] .. fwd_bus[NUM_FWD-1], then wb_to_rf_bus, then regfile; a source matches only if we=1, waddr==addr, addr!=0.
REQ-019 Reads of $0 return 0 regardless of forwarding or writes.
REQ-020 Decode set: addu subu slt sltu and or xor nor sll srl sra jr jalr addiu slti sltiu andi ori xori lui j jal beq bne lw sw; any other opcode decodes as nop.
REQ-021 alu_op one-hot order {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}; sel_src1 {sa,pc,rs}; sel_src2 {imm_zext,8,imm_sext,rt}.
REQ-022 Destination: R-type rd; I-type and lw rt; jal $31; jalr rd; jal/jalr use pc+8 via alu add.
REQ-023 Branch targets: beq/bne pc+4+(sext(imm)<<2); j/jal {pc[31:28],index,2'b00}; jr/jalr data1; br_e combinational, same cycle as decode.
REQ-024 lw: ram_en=1, ram_wen=0, rf_we=1, sel_rf_res=1; sw: ram_en=1, ram_wen=4'b1111, rf_we=0.
REQ-025 stallreq=1 when ce=1, ex_is_load=1, ex_load_waddr!=0 and equals rs (if instruction reads rs) or rt (if reads rt); combinational; br_e and rf_we/ram_en in the bus forced 0 while stallreq=1.
REQ-026 Only one load-use stall cycle per hazard; on release the load value arrives via fwd_bus.
REQ-027 flush concurrent with stall: flush wins.

Reset
REQ-028 rst low asynchronously clears pipeline register, hold register, hold_valid; outputs then: id_to_ex_bus all 0 except inst/data derived from nop, br_bus 0, stallreq 0.
REQ-029 Regfile contents are not reset; reads of $0 stay 0.
REQ-030 Reset mid-stall drops any held instruction; first fetch after release decodes fresh.

Structure
REQ-031 Bus widths, stall bit indices, opcode/func codes and alu_op bit positions live in the shared defines header.
REQ-032 Reuse existing regfile as sole sub-module; forwarding mux is a generate loop over NUM_FWD.

Verification
REQ-033 Reset, then ori $1,$0,0x1234 -> data1=0, rf_waddr=1, sel_src2=4'b1000, rf_we=1.
REQ-034 fwd[0]={1,3,0xAAAA}, fwd[1]={1,3,0xBBBB}, addu $4,$3,$3 -> data1=data2=0xAAAA; same with waddr=0 -> data=0.
REQ-035 ex_is_load=1, ex_load_waddr=5, addu $6,$5,$2 -> stallreq=1, bus rf_we=0; next cycle ex_is_load=0 -> stallreq=0, normal decode.
REQ-036 stall[1]=1,stall[2]=1 for 3 cycles with inst_sram_rdata changing -> decoded inst stays original; resumes correctly.
REQ-037 beq $1,$2,+4 at pc 0xBFC00000 with data1==data2 -> br_e=1, br_addr=0xBFC00014; bne same -> br_e=0.
REQ-038 flush asserted with stall[1]=1 -> next cycle id_to_ex_bus is bubble, hold_valid=0.
